vc_queue: RTL and testbench

VC_QUEUE -- requirements
Module: vc_queue

---
 rtl/vc_queue_pkg.sv | 24 ++
 rtl/vc_queue_if.sv | 32 +++
 rtl/vc_queue_ctrl.sv | 86 ++++++++
 rtl/vc_queue.sv | 77 +++++++
 tb/tb_vc_queue.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_queue_pkg.sv
// Shared width helpers and bypass-mode constants for the virtual-channel queue.
package vc_queue_pkg;

  typedef enum logic {
    BYPASS_OFF = 1'b0,
    BYPASS_ON  = 1'b1
  } bypass_mode_e;

  // Value of p_bypass that turns on same-cycle enq-to-deq forwarding.
  localparam int c_bypass_on = 32'sd1;

  function automatic int count_width(input int num_entries);
    return $clog2(num_entries + 32'sd1);
  endfunction

  function automatic int vc_width(input int num_vcs);
    return (num_vcs == 32'sd1) ? 32'sd1 : $clog2(num_vcs);
  endfunction

  function automatic int ptr_width(input int num_entries);
    return (num_entries == 32'sd1) ? 32'sd1 : $clog2(num_entries);
  endfunction

endpackage

// File: rtl/vc_queue_if.sv
// Enqueue/dequeue handshake bundle; master is the traffic source/sink, slave is the queue.
interface vc_queue_if #(
  parameter int p_data_width  = 32,
  parameter int p_num_entries = 2,
  parameter int p_num_vcs     = 2
);
  import vc_queue_pkg::*;

  localparam int c_count_width = count_width(p_num_entries);
  localparam int c_vc_width    = vc_width(p_num_vcs);

  logic                               enq_en;
  logic [c_vc_width-1:0]              enq_vc;
  logic [p_data_width-1:0]            enq_msg;
  logic [p_num_vcs-1:0]               enq_rdy;
  logic                               deq_en;
  logic [c_vc_width-1:0]              deq_vc;
  logic [p_data_width-1:0]            deq_msg;
  logic [p_num_vcs-1:0]               deq_rdy;
  logic [p_num_vcs*c_count_width-1:0] count;

  modport master (
    output enq_en, enq_vc, enq_msg, deq_en, deq_vc,
    input  enq_rdy, deq_msg, deq_rdy, count
  );

  modport slave (
    input  enq_en, enq_vc, enq_msg, deq_en, deq_vc,
    output enq_rdy, deq_msg, deq_rdy, count
  );

endinterface

// File: rtl/vc_queue_ctrl.sv
// Pointer/occupancy bookkeeping for a single virtual channel; the payload storage lives in the parent.
module vc_queue_ctrl
  import vc_queue_pkg::*;
#(
  parameter int           p_num_entries = 2,
  parameter bypass_mode_e p_mode        = BYPASS_OFF,
  localparam int          c_count_width = count_width(p_num_entries),
  localparam int          c_ptr_width   = ptr_width(p_num_entries)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enq_sel_i,
  input  logic                     deq_sel_i,
  output logic                     enq_rdy_o,
  output logic                     deq_rdy_o,
  output logic                     wr_en_o,
  output logic                     bypass_o,
  output logic [c_ptr_width-1:0]   enq_ptr_o,
  output logic [c_ptr_width-1:0]   deq_ptr_o,
  output logic [c_count_width-1:0] count_o
);

  localparam logic [c_count_width-1:0] c_full = c_count_width'(p_num_entries);
  localparam logic [c_ptr_width-1:0]   c_last = c_ptr_width'(p_num_entries - 32'sd1);

  logic [c_ptr_width-1:0]   enq_ptr_q, enq_ptr_d;
  logic [c_ptr_width-1:0]   deq_ptr_q, deq_ptr_d;
  logic [c_count_width-1:0] count_q, count_d;
  logic                     empty_s, enq_fire_s, deq_fire_s, byp_xfer_s, do_enq_s, do_deq_s;

  function automatic logic [c_ptr_width-1:0] ptr_inc(input logic [c_ptr_width-1:0] ptr);
    return (ptr == c_last) ? {c_ptr_width{1'b0}} : ptr + c_ptr_width'(1);
  endfunction

  assign empty_s    = (count_q == {c_count_width{1'b0}});
  assign enq_rdy_o  = (count_q < c_full);
  assign deq_rdy_o  = !empty_s || ((p_mode == BYPASS_ON) && enq_sel_i);
  assign bypass_o   = (p_mode == BYPASS_ON) && empty_s && enq_sel_i;
  assign enq_fire_s = enq_sel_i && enq_rdy_o;
  assign deq_fire_s = deq_sel_i && deq_rdy_o;
  // A forwarded message never touches storage, so neither side advances.
  assign byp_xfer_s = bypass_o && enq_fire_s && deq_fire_s;
  assign do_enq_s   = enq_fire_s && !byp_xfer_s;
  assign do_deq_s   = deq_fire_s && !byp_xfer_s;

  assign wr_en_o   = do_enq_s;
  assign enq_ptr_o = enq_ptr_q;
  assign deq_ptr_o = deq_ptr_q;
  assign count_o   = count_q;

  // Next-state for pointers and occupancy.
  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (do_enq_s) begin
      enq_ptr_d = ptr_inc(enq_ptr_q);
    end else begin
      enq_ptr_d = enq_ptr_q;
    end
    if (do_deq_s) begin
      deq_ptr_d = ptr_inc(deq_ptr_q);
    end else begin
      deq_ptr_d = deq_ptr_q;
    end
    case ({do_enq_s, do_deq_s})
      2'b10:   count_d = count_q + c_count_width'(1);
      2'b01:   count_d = count_q - c_count_width'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_q <= {c_ptr_width{1'b0}};
      deq_ptr_q <= {c_ptr_width{1'b0}};
      count_q   <= {c_count_width{1'b0}};
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/vc_queue.sv
// Multi-VC FIFO: one control slice and one un-reset storage bank per VC, plus the head-of-line mux.
module vc_queue
  import vc_queue_pkg::*;
#(
  parameter int p_data_width  = 32,
  parameter int p_num_entries = 2,
  parameter int p_num_vcs     = 2,
  parameter int p_bypass      = 0
) (
  input  logic      clk,
  input  logic      reset_n,
  vc_queue_if.slave vcq
);

  localparam int           c_count_width = count_width(p_num_entries);
  localparam int           c_ptr_width   = ptr_width(p_num_entries);
  localparam bypass_mode_e c_mode        = (p_bypass == c_bypass_on) ? BYPASS_ON : BYPASS_OFF;

  logic [p_num_vcs-1:0]                    enq_rdy_s, deq_rdy_s, wr_en_s, bypass_s;
  logic [p_num_vcs-1:0][c_ptr_width-1:0]   enq_ptr_s, deq_ptr_s;
  logic [p_num_vcs-1:0][c_count_width-1:0] count_s;
  logic [p_data_width-1:0]                 head_s [p_num_vcs];
  logic [p_data_width-1:0]                 deq_msg_s;
  logic                                    deq_vc_ok_s;

  for (genvar v = 0; v < p_num_vcs; v++) begin : g_vc
    logic [p_data_width-1:0] mem_q [p_num_entries];

    vc_queue_ctrl #(
      .p_num_entries (p_num_entries),
      .p_mode        (c_mode)
    ) u_ctrl (
      .clk       (clk),
      .reset_n   (reset_n),
      .enq_sel_i (vcq.enq_en && (int'(vcq.enq_vc) == v)),
      .deq_sel_i (vcq.deq_en && (int'(vcq.deq_vc) == v)),
      .enq_rdy_o (enq_rdy_s[v]),
      .deq_rdy_o (deq_rdy_s[v]),
      .wr_en_o   (wr_en_s[v]),
      .bypass_o  (bypass_s[v]),
      .enq_ptr_o (enq_ptr_s[v]),
      .deq_ptr_o (deq_ptr_s[v]),
      .count_o   (count_s[v])
    );

    // Payload bank; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
      if (wr_en_s[v]) begin
        mem_q[enq_ptr_s[v]] <= vcq.enq_msg;
      end
    end

    assign head_s[v] = mem_q[deq_ptr_s[v]];
  end

  assign deq_vc_ok_s = (int'(vcq.deq_vc) < p_num_vcs);

  // Head-of-line select; an empty VC being written this cycle forwards enq_msg in bypass mode.
  always_comb begin
    deq_msg_s = {p_data_width{1'b0}};
    if (deq_vc_ok_s) begin
      if (bypass_s[vcq.deq_vc]) begin
        deq_msg_s = vcq.enq_msg;
      end else begin
        deq_msg_s = head_s[vcq.deq_vc];
      end
    end else begin
      deq_msg_s = {p_data_width{1'b0}};
    end
  end

  assign vcq.enq_rdy = enq_rdy_s;
  assign vcq.deq_rdy = deq_rdy_s;
  assign vcq.deq_msg = deq_msg_s;
  assign vcq.count   = count_s;

endmodule

// File: tb/tb_vc_queue.sv
// Bench for vc_queue: three configurations (default, bypass, 3x3) checked against per-VC queue models.
module tb_vc_queue;
  import vc_queue_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vc_queue_if #(.p_data_width(32), .p_num_entries(2), .p_num_vcs(2)) if0 ();
  vc_queue_if #(.p_data_width(32), .p_num_entries(2), .p_num_vcs(2)) if1 ();
  vc_queue_if #(.p_data_width(32), .p_num_entries(3), .p_num_vcs(3)) if2 ();

  vc_queue #(.p_data_width(32), .p_num_entries(2), .p_num_vcs(2), .p_bypass(0))
    u_dut0 (.clk(clk), .reset_n(reset_n), .vcq(if0));
  vc_queue #(.p_data_width(32), .p_num_entries(2), .p_num_vcs(2), .p_bypass(1))
    u_dut1 (.clk(clk), .reset_n(reset_n), .vcq(if1));
  vc_queue #(.p_data_width(32), .p_num_entries(3), .p_num_vcs(3), .p_bypass(0))
    u_dut2 (.clk(clk), .reset_n(reset_n), .vcq(if2));

  int tests_run    = 0;
  int tests_failed = 0;

  int  n_ent [3] = '{2, 2, 3};
  int  n_vc  [3] = '{2, 2, 3};
  bit  byp   [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] mq [3][3][$];

  logic [2:0]  o_er, o_dr;
  logic [31:0] o_dm;
  logic [5:0]  o_cn;

  task automatic drive(input int d, input bit ee, input int ev, input logic [31:0] em,
                       input bit de, input int dv);
    case (d)
      0: begin
        if0.enq_en = ee; if0.enq_vc = 1'(ev); if0.enq_msg = em;
        if0.deq_en = de; if0.deq_vc = 1'(dv);
      end
      1: begin
        if1.enq_en = ee; if1.enq_vc = 1'(ev); if1.enq_msg = em;
        if1.deq_en = de; if1.deq_vc = 1'(dv);
      end
      default: begin
        if2.enq_en = ee; if2.enq_vc = 2'(ev); if2.enq_msg = em;
        if2.deq_en = de; if2.deq_vc = 2'(dv);
      end
    endcase
  endtask

  task automatic sample(input int d);
    case (d)
      0: begin
        o_er = {1'b0, if0.enq_rdy}; o_dr = {1'b0, if0.deq_rdy};
        o_dm = if0.deq_msg;         o_cn = {2'b00, if0.count};
      end
      1: begin
        o_er = {1'b0, if1.enq_rdy}; o_dr = {1'b0, if1.deq_rdy};
        o_dm = if1.deq_msg;         o_cn = {2'b00, if1.count};
      end
      default: begin
        o_er = if2.enq_rdy; o_dr = if2.deq_rdy;
        o_dm = if2.deq_msg; o_cn = if2.count;
      end
    endcase
  endtask

  function automatic void m_clear();
    for (int d = 0; d < 3; d++)
      for (int v = 0; v < 3; v++) mq[d][v].delete();
  endfunction

  function automatic logic [2:0] m_enq_rdy(input int d);
    logic [2:0] r = 3'b000;
    for (int v = 0; v < n_vc[d]; v++) r[v] = (mq[d][v].size() < n_ent[d]);
    return r;
  endfunction

  function automatic logic [2:0] m_deq_rdy(input int d, input bit ee, input int ev);
    logic [2:0] r = 3'b000;
    for (int v = 0; v < n_vc[d]; v++)
      r[v] = (mq[d][v].size() > 0) || (byp[d] && ee && (ev == v));
    return r;
  endfunction

  function automatic logic [5:0] m_count(input int d);
    logic [5:0] r = 6'd0;
    for (int v = 0; v < n_vc[d]; v++) r[v*2 +: 2] = 2'(mq[d][v].size());
    return r;
  endfunction

  // Apply one cycle of the queue rules to the model.
  function automatic void m_update(input int d, input bit ee, input int ev, input logic [31:0] em,
                                   input bit de, input int dv);
    bit enq_ok = 1'b0;
    bit deq_ok = 1'b0;
    bit dv_empty = 1'b0;
    if (ee && ev < n_vc[d]) enq_ok = (mq[d][ev].size() < n_ent[d]);
    if (de && dv < n_vc[d]) begin
      dv_empty = (mq[d][dv].size() == 0);
      deq_ok   = !dv_empty || (byp[d] && ee && ev == dv);
    end
    if (enq_ok && deq_ok && dv_empty) return;
    if (deq_ok) void'(mq[d][dv].pop_front());
    if (enq_ok) mq[d][ev].push_back(em);
  endfunction

  task automatic step(input int d, input bit ee, input int ev, input logic [31:0] em,
                      input bit de, input int dv);
    @(posedge clk); #1;
    drive(d, ee, ev, em, de, dv);
    #2;
    sample(d);
    m_update(d, ee, ev, em, de, dv);
  endtask

  task automatic test_reset();
    logic [2:0] all_rdy;
    for (int d = 0; d < 3; d++) begin
      all_rdy = (d == 2) ? 3'b111 : 3'b011;
      step(d, 1'b0, 0, 32'h0, 1'b0, 0);
      tests_run++;
      if (o_cn !== 6'd0) begin tests_failed++; $display("FAIL reset_count d%0d: got %h expected 0", d, o_cn); end
      tests_run++;
      if (o_er !== all_rdy) begin tests_failed++; $display("FAIL reset_enq_rdy d%0d: got %b expected %b", d, o_er, all_rdy); end
      tests_run++;
      if (o_dr !== 3'b000) begin tests_failed++; $display("FAIL reset_deq_rdy d%0d: got %b expected 000", d, o_dr); end
    end
  endtask

  task automatic test_basic();
    step(0, 1'b1, 0, 32'hA, 1'b0, 0);
    step(0, 1'b1, 0, 32'hB, 1'b0, 0);
    tests_run++;
    if (o_dr[0] !== 1'b1 || o_dm !== 32'hA) begin
      tests_failed++; $display("FAIL basic_latency: got rdy %b msg %h expected 1 0000000a", o_dr[0], o_dm);
    end
    step(0, 1'b0, 0, 32'h0, 1'b0, 0);
    tests_run++;
    if (o_er[0] !== 1'b0 || o_cn[1:0] !== 2'd2) begin
      tests_failed++; $display("FAIL basic_full: got enq_rdy %b count %0d expected 0 2", o_er[0], o_cn[1:0]);
    end
    step(0, 1'b0, 0, 32'h0, 1'b1, 0);
    tests_run++;
    if (o_dm !== 32'hA) begin tests_failed++; $display("FAIL basic_deq1: got %h expected a", o_dm); end
    step(0, 1'b0, 0, 32'h0, 1'b1, 0);
    tests_run++;
    if (o_dm !== 32'hB || o_cn[1:0] !== 2'd1) begin
      tests_failed++; $display("FAIL basic_deq2: got msg %h count %0d expected b 1", o_dm, o_cn[1:0]);
    end
    step(0, 1'b0, 0, 32'h0, 1'b0, 0);
    tests_run++;
    if (o_dr[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_empty: got deq_rdy %b expected 0", o_dr[0]); end
  endtask

  task automatic test_interleave();
    step(0, 1'b1, 0, 32'h1, 1'b0, 0);
    step(0, 1'b1, 1, 32'h2, 1'b0, 0);
    step(0, 1'b1, 0, 32'h3, 1'b0, 0);
    step(0, 1'b0, 0, 32'h0, 1'b1, 1);
    tests_run++;
    if (o_dm !== 32'h2) begin tests_failed++; $display("FAIL interleave_vc1: got %h expected 2", o_dm); end
    step(0, 1'b0, 0, 32'h0, 1'b1, 0);
    tests_run++;
    if (o_dm !== 32'h1) begin tests_failed++; $display("FAIL interleave_vc0a: got %h expected 1", o_dm); end
    step(0, 1'b0, 0, 32'h0, 1'b1, 0);
    tests_run++;
    if (o_dm !== 32'h3) begin tests_failed++; $display("FAIL interleave_vc0b: got %h expected 3", o_dm); end
    step(0, 1'b0, 0, 32'h0, 1'b0, 0);
    tests_run++;
    if (o_cn !== 6'd0) begin tests_failed++; $display("FAIL interleave_drain: got count %h expected 0", o_cn); end
  endtask

  task automatic test_full_enq_deq();
    step(0, 1'b1, 0, 32'hA, 1'b0, 0);
    step(0, 1'b1, 0, 32'hB, 1'b0, 0);
    step(0, 1'b1, 0, 32'hC, 1'b1, 0);
    tests_run++;
    if (o_er[0] !== 1'b0 || o_dm !== 32'hA) begin
      tests_failed++; $display("FAIL full_same_cycle: got enq_rdy %b msg %h expected 0 a", o_er[0], o_dm);
    end
    step(0, 1'b0, 0, 32'h0, 1'b0, 0);
    tests_run++;
    if (o_cn[1:0] !== 2'd1 || o_dm !== 32'hB) begin
      tests_failed++; $display("FAIL full_after: got count %0d head %h expected 1 b", o_cn[1:0], o_dm);
    end
    step(0, 1'b0, 0, 32'h0, 1'b1, 0);
    step(0, 1'b0, 0, 32'h0, 1'b0, 0);
    tests_run++;
    if (o_cn !== 6'd0) begin tests_failed++; $display("FAIL full_drain: got count %h expected 0 (C must be dropped)", o_cn); end
  endtask

  task automatic test_bypass();
    step(1, 1'b1, 1, 32'h55, 1'b1, 1);
    tests_run++;
    if (o_dr[1] !== 1'b1 || o_dm !== 32'h55) begin
      tests_failed++; $display("FAIL bypass_pass: got rdy %b msg %h expected 1 55", o_dr[1], o_dm);
    end
    step(1, 1'b0, 0, 32'h0, 1'b0, 1);
    tests_run++;
    if (o_cn[3:2] !== 2'd0 || o_dr[1] !== 1'b0) begin
      tests_failed++; $display("FAIL bypass_no_store: got count %0d rdy %b expected 0 0", o_cn[3:2], o_dr[1]);
    end
    step(1, 1'b1, 1, 32'h66, 1'b0, 1);
    step(1, 1'b1, 1, 32'h77, 1'b1, 1);
    tests_run++;
    if (o_dm !== 32'h66) begin tests_failed++; $display("FAIL bypass_nonempty_head: got %h expected 66", o_dm); end
    step(1, 1'b0, 0, 32'h0, 1'b1, 1);
    tests_run++;
    if (o_dm !== 32'h77) begin tests_failed++; $display("FAIL bypass_order: got %h expected 77", o_dm); end
    step(1, 1'b0, 0, 32'h0, 1'b0, 1);
    step(0, 1'b1, 1, 32'h55, 1'b1, 1);
    tests_run++;
    if (o_dr[1] !== 1'b0) begin tests_failed++; $display("FAIL nobypass_rdy: got %b expected 0", o_dr[1]); end
    step(0, 1'b0, 0, 32'h0, 1'b0, 1);
    tests_run++;
    if (o_cn[3:2] !== 2'd1 || o_dm !== 32'h55) begin
      tests_failed++; $display("FAIL nobypass_store: got count %0d msg %h expected 1 55", o_cn[3:2], o_dm);
    end
    step(0, 1'b0, 0, 32'h0, 1'b1, 1);
    step(0, 1'b0, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_wrap();
    step(2, 1'b1, 0, 32'd100, 1'b0, 0);
    for (int i = 0; i < 7; i++) begin
      step(2, 1'b1, 0, 32'd101 + 32'(i), 1'b1, 0);
      tests_run++;
      if (o_dm !== 32'd100 + 32'(i) || o_cn[1:0] !== 2'd1) begin
        tests_failed++; $display("FAIL wrap_pair%0d: got msg %0d count %0d expected %0d 1", i, o_dm, o_cn[1:0], 100 + i);
      end
    end
    step(2, 1'b1, 0, 32'd200, 1'b1, 0);
    step(2, 1'b1, 0, 32'd201, 1'b0, 0);
    step(2, 1'b1, 0, 32'd202, 1'b0, 0);
    step(2, 1'b1, 0, 32'd203, 1'b0, 0);
    tests_run++;
    if (o_cn[1:0] !== 2'd3 || o_er[0] !== 1'b0) begin
      tests_failed++; $display("FAIL wrap_full: got count %0d enq_rdy %b expected 3 0", o_cn[1:0], o_er[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step(2, 1'b0, 0, 32'h0, 1'b1, 0);
      tests_run++;
      if (o_dm !== 32'd200 + 32'(i)) begin
        tests_failed++; $display("FAIL wrap_drain%0d: got %0d expected %0d", i, o_dm, 200 + i);
      end
    end
    step(2, 1'b0, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_out_of_range();
    step(2, 1'b1, 3, 32'hDEAD, 1'b0, 0);
    step(2, 1'b0, 0, 32'h0, 1'b1, 3);
    tests_run++;
    if (o_cn !== 6'd0 || o_dr !== 3'b000) begin
      tests_failed++; $display("FAIL oor_enq: got count %h deq_rdy %b expected 0 000", o_cn, o_dr);
    end
    step(2, 1'b0, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_async_reset();
    step(0, 1'b1, 0, 32'hA, 1'b0, 0);
    step(0, 1'b1, 0, 32'hB, 1'b0, 0);
    step(0, 1'b0, 0, 32'h0, 1'b0, 0);
    tests_run++;
    if (o_cn[1:0] !== 2'd2) begin tests_failed++; $display("FAIL areset_pre: got count %0d expected 2", o_cn[1:0]); end
    #1; reset_n = 1'b0;
    #1;
    tests_run++;
    if (if0.count !== 4'h0 || if0.deq_rdy !== 2'b00 || if0.enq_rdy !== 2'b11) begin
      tests_failed++;
      $display("FAIL areset_immediate: got count %h deq_rdy %b enq_rdy %b expected 0 00 11",
               if0.count, if0.deq_rdy, if0.enq_rdy);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_clear();
    drive(0, 1'b1, 0, 32'h77, 1'b0, 0);
    mq[0][0].push_back(32'h77);
    step(0, 1'b0, 0, 32'h0, 1'b0, 0);
    tests_run++;
    if (o_cn[1:0] !== 2'd1 || o_dm !== 32'h77) begin
      tests_failed++; $display("FAIL areset_first_enq: got count %0d msg %h expected 1 77", o_cn[1:0], o_dm);
    end
    step(0, 1'b0, 0, 32'h0, 1'b1, 0);
    step(0, 1'b0, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_random();
    bit ee, de, x_dm_valid;
    int ev, dv;
    logic [31:0] em, x_dm;
    logic [2:0] x_er, x_dr;
    logic [5:0] x_cn;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 300; c++) begin
        ee = ($urandom_range(0, 3) != 0);
        de = ($urandom_range(0, 2) != 0);
        ev = $urandom_range(0, (d == 2) ? 3 : 1);
        dv = $urandom_range(0, (d == 2) ? 3 : 1);
        em = $urandom();
        x_er = m_enq_rdy(d);
        x_dr = m_deq_rdy(d, ee, ev);
        x_cn = m_count(d);
        x_dm_valid = 1'b0;
        x_dm = 32'h0;
        if (dv < n_vc[d]) begin
          if (mq[d][dv].size() > 0) begin
            x_dm_valid = 1'b1; x_dm = mq[d][dv][0];
          end else if (byp[d] && ee && ev == dv) begin
            x_dm_valid = 1'b1; x_dm = em;
          end
        end
        step(d, ee, ev, em, de, dv);
        tests_run++;
        if (o_er !== x_er) begin tests_failed++; $display("FAIL rand_enq_rdy d%0d c%0d: got %b expected %b", d, c, o_er, x_er); end
        tests_run++;
        if (o_dr !== x_dr) begin tests_failed++; $display("FAIL rand_deq_rdy d%0d c%0d: got %b expected %b", d, c, o_dr, x_dr); end
        tests_run++;
        if (o_cn !== x_cn) begin tests_failed++; $display("FAIL rand_count d%0d c%0d: got %h expected %h", d, c, o_cn, x_cn); end
        if (x_dm_valid) begin
          tests_run++;
          if (o_dm !== x_dm) begin tests_failed++; $display("FAIL rand_deq_msg d%0d c%0d: got %h expected %h", d, c, o_dm, x_dm); end
        end
      end
      step(d, 1'b0, 0, 32'h0, 1'b0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    m_clear();
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 0, 32'h0, 1'b0, 0);
    #12;
    @(posedge clk); #1;
    reset_n = 1'b1;
    test_reset();
    test_basic();
    test_interleave();
    test_full_enq_deq();
    test_bypass();
    test_wrap();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
